out_bus_arbiter: RTL and testbench
==================================

# out_bus_arbiter

Sequences and arbitrates the CPU core's 8-bit outbound serial bus between its three 16-bit shift-register sources: MAR, MDR and PC.
- Grants one source at a time and drives the one-hot bus selects.
- Offers each byte to the external Arduino with a valid/ready handshake.
- Pulses the owner's shift-out strobe between bytes, and reports completion per source.

It sits between the control FSM, which raises requests, and the MAR/MDR/PC shift registers plus the `out_bus` mux.

## Interface
Parameters:
- `NUM_BYTES`, default 2: bytes per transfer; must be ≥ 1.
- `TIMEOUT_CYCLES`, default 255: handshake watchdog limit; used only with `OUT_BUS_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_mar`, `req_mdr`, `req_pc`  in  1 each  level requests from the control FSM.
- `ard_receive_ready`  in  1  Arduino has captured the offered byte (level).
- `bus_mar`, `bus_mdr`, `bus_pc`  out  1 each  one-hot bus select; all 0 when idle.
- `mar_shift_out`, `mdr_shift_out`, `pc_shift_out`  out  1 each  one-cycle shift strobe to the owner.
- `byte_valid`  out  1  a byte is on `out_bus` and is being offered.
- `done_mar`, `done_mdr`, `done_pc`  out  1 each  one-cycle completion pulse.
- `busy`  out  1  a transfer is in progress (state is not IDLE).
- `error`  out  1  sticky handshake timeout; tied 0 without the macro.

## Operation
- States: IDLE, SEND, SHIFT, RELEASE, DONE.
- **IDLE**
  - Samples requests with fixed priority MAR > MDR > PC (address before data on stores).
  - Latches the winner as owner, clears byte count `cnt` to 0, and moves to SEND.
  - With no request, stays in IDLE.
- **SEND**
  - Owner's select = 1 and `byte_valid` = 1.
  - On `ard_receive_ready` = 1, moves to SHIFT.
- **SHIFT** (one cycle)
  - Select is held; `byte_valid` = 0.
  - Pulses the owner's `*_shift_out` only if `cnt` != `NUM_BYTES`-1; the last byte is never shifted past.
  - Moves to RELEASE.
- **RELEASE**
  - Select is held; `byte_valid` = 0.
  - Waits for `ard_receive_ready` = 0. One held-high ready never counts as two bytes.
  - On ready low: if `cnt` = `NUM_BYTES`-1, moves to DONE; otherwise increments `cnt` and returns to SEND.
- **DONE** (one cycle)
  - Owner's `done_*` = 1; all selects = 0.
  - Moves to IDLE.
- Owner lock
  - A request dropped mid-transfer is ignored; the transfer completes.
  - Higher-priority requests arriving mid-transfer wait for IDLE.
- Requesters must deassert `req` no later than the cycle after their `done_*`; a request still high in IDLE is re-granted.
- Selects are exactly one-hot while not IDLE/DONE and never change mid-transfer.
- `cnt` width is `$clog2(NUM_BYTES)` (minimum 1 bit). For `NUM_BYTES` = 1, no shift strobe is ever issued.

## Timing
- Reset values: state IDLE, `cnt` 0, all selects/strobes/done/`byte_valid`/`busy`/`error` 0.
- All outputs are decoded from registered state and owner only; there is no combinational path from `req_*` or `ard_receive_ready`.
- Request high in IDLE at cycle 0: select and `byte_valid` assert at cycle 1.
- Fastest byte (ready high in first SEND cycle, low one cycle later) takes 3 cycles: SEND, SHIFT, RELEASE.
- Fastest 2-byte transfer: `done_*` at cycle 7; next grant possible at cycle 9.
- `rst` mid-transfer aborts immediately to the reset values, with no `done_*` pulse.

## Configuration
- `OUT_BUS_TIMEOUT_EN` defined
  - A watchdog counts consecutive cycles spent in SEND or RELEASE; it clears on every state change.
  - On reaching `TIMEOUT_CYCLES`, it sets `error` (sticky until `rst`) and moves to IDLE next cycle without `done_*`.
- Undefined: no counter; `error` is constant 0 and the block waits indefinitely.

## Structure
- Shared package entries:
  - `out_arb_state_t` enum (IDLE, SEND, SHIFT, RELEASE, DONE).
  - `bus_src_t` enum (SRC_NONE, SRC_MAR, SRC_MDR, SRC_PC).
  - Default `NUM_BYTES` constant.
- Sub-module: `out_bus_watchdog` (counter + sticky flag), instantiated only under `OUT_BUS_TIMEOUT_EN`.
- Arbitration logic stays inline.

## Test plan
- **Single PC transfer:** `req_pc`=1 at cycle 0; ready pulses high for one cycle each time `byte_valid` is seen.
  - Expect `bus_pc` high cycles 1–6 and `pc_shift_out` exactly once, at cycle 2.
  - Expect `done_pc` at cycle 7 and `busy` 0 at cycle 8.
- **Priority:** `req_pc`, `req_mdr`, `req_mar` all raised at cycle 0, each dropped after its done.
  - Expect grant order MAR, MDR, PC and three `done_*` pulses in that order.
  - Expect no select overlap at any cycle.
- **Held ready:** `ard_receive_ready` stuck high for 10 cycles after the first SEND.
  - Expect the arbiter to stay in RELEASE with `cnt`=0 and no second shift.
  - Release ready: the second byte is offered 1 cycle later.
- **Lock:** `req_mar` asserted while a PC transfer is in its first RELEASE.
  - Expect the PC transfer to complete (`done_pc`) and `bus_mar` to rise 2 cycles after `done_pc`.
- **Reset mid-op:** `rst`=1 during the second SEND of an MDR transfer.
  - Expect all outputs 0 the next cycle and no `done_mdr`.
- **Timeout (macro on, `TIMEOUT_CYCLES`=8):** request with ready never asserted.
  - Expect `error`=1 after 8 SEND cycles, then return to IDLE with `error` still 1 and no done.
  - Expect `error` cleared only by `rst`.

Source files
------------

// File: rtl/out_bus_arbiter_pkg.sv
// out_bus_arbiter_pkg
// Shared types and constants for the outbound serial bus arbiter.
//   out_arb_state_t : arbiter FSM states
//   bus_src_t       : identity of the shift register that owns the bus
//   OUT_BUS_NUM_BYTES_DEFAULT : default number of bytes per transfer
package out_bus_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        SHIFT   = 3'd2,
        RELEASE = 3'd3,
        DONE    = 3'd4
    } out_arb_state_t;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_MAR  = 2'd1,
        SRC_MDR  = 2'd2,
        SRC_PC   = 2'd3
    } bus_src_t;

    localparam int OUT_BUS_NUM_BYTES_DEFAULT = 2;

endpackage

// File: rtl/out_bus_watchdog.sv
// out_bus_watchdog
// Counts consecutive cycles the arbiter spends waiting on the Arduino
// handshake and flags a sticky error when the limit is reached.
// Ports:
//   clk, rst  : clock and synchronous active-high reset
//   active    : arbiter is in a handshake wait state (SEND or RELEASE)
//   restart   : arbiter state changes this cycle; the count starts over
//   expire    : this is the TIMEOUT_CYCLES-th consecutive wait cycle
//   error     : sticky timeout flag, cleared only by rst
module out_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic restart,
    output logic expire,
    output logic error
);

    localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [W-1:0] LIMIT_M1 = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt_r;
    logic         error_r;

    // Counter value N means N earlier wait cycles in the current state,
    // so the expiring cycle is the one that sees LIMIT-1.
    assign expire = active && (cnt_r == LIMIT_M1);
    assign error  = error_r;

    // Wait-cycle counter and sticky error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= '0;
            error_r <= 1'b0;
        end else begin
            if (!active || restart || expire) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + W'(1);
            end
            if (expire) begin
                error_r <= 1'b1;
            end else begin
                error_r <= error_r;
            end
        end
    end

endmodule

// File: rtl/out_bus_arbiter.sv
// out_bus_arbiter
// Arbitrates the CPU's 8-bit outbound serial bus between the MAR, MDR and
// PC shift registers (fixed priority MAR > MDR > PC), offers each byte to
// the Arduino with a valid/ready handshake, strobes the owner's shift-out
// between bytes and pulses a per-source done when the transfer completes.
// Optional build macro: OUT_BUS_TIMEOUT_EN adds a handshake watchdog that
// aborts a stalled transfer and raises a sticky error.
// Ports:
//   clk, rst                    : clock, synchronous active-high reset
//   req_mar/req_mdr/req_pc      : level requests from the control FSM
//   ard_receive_ready           : Arduino captured the offered byte (level)
//   bus_mar/bus_mdr/bus_pc      : one-hot bus select, all 0 when idle
//   *_shift_out                 : one-cycle shift strobe to the owner
//   byte_valid                  : a byte is being offered on out_bus
//   done_mar/done_mdr/done_pc   : one-cycle completion pulse
//   busy                        : a transfer is in progress
//   error                       : sticky handshake timeout
module out_bus_arbiter
    import out_bus_arbiter_pkg::*;
#(
    parameter int NUM_BYTES      = OUT_BUS_NUM_BYTES_DEFAULT,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic req_mar,
    input  logic req_mdr,
    input  logic req_pc,
    input  logic ard_receive_ready,
    output logic bus_mar,
    output logic bus_mdr,
    output logic bus_pc,
    output logic mar_shift_out,
    output logic mdr_shift_out,
    output logic pc_shift_out,
    output logic byte_valid,
    output logic done_mar,
    output logic done_mdr,
    output logic done_pc,
    output logic busy,
    output logic error
);

    localparam int CNT_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

    out_arb_state_t   state_r, state_s;
    bus_src_t         owner_r, owner_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             timeout_s;
    logic             sel_on_s;
    logic             shift_on_s;

`ifdef OUT_BUS_TIMEOUT_EN
    logic wait_s;
    logic restart_s;

    assign wait_s    = (state_r == SEND) || (state_r == RELEASE);
    assign restart_s = (state_s != state_r);

    out_bus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .active (wait_s),
        .restart(restart_s),
        .expire (timeout_s),
        .error  (error)
    );
`else
    // No watchdog: never abort, and error is constant 0. The limit is only
    // referenced so the parameter stays part of the interface.
    assign timeout_s = 1'b0;
    assign error     = (TIMEOUT_CYCLES < 1) & 1'b0;
`endif

    // State, owner and byte-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            owner_r <= SRC_NONE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next-state, owner and byte-count logic.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        cnt_s   = cnt_r;
        if (timeout_s) begin
            state_s = IDLE;
            owner_s = SRC_NONE;
            cnt_s   = '0;
        end else begin
            case (state_r)
                IDLE: begin
                    cnt_s = '0;
                    if (req_mar) begin
                        owner_s = SRC_MAR;
                        state_s = SEND;
                    end else if (req_mdr) begin
                        owner_s = SRC_MDR;
                        state_s = SEND;
                    end else if (req_pc) begin
                        owner_s = SRC_PC;
                        state_s = SEND;
                    end else begin
                        owner_s = SRC_NONE;
                        state_s = IDLE;
                    end
                end
                SEND: begin
                    if (ard_receive_ready) begin
                        state_s = SHIFT;
                    end else begin
                        state_s = SEND;
                    end
                end
                SHIFT: begin
                    state_s = RELEASE;
                end
                RELEASE: begin
                    // Waiting for ready to fall keeps one long ready level
                    // from being counted as two bytes.
                    if (ard_receive_ready) begin
                        state_s = RELEASE;
                    end else if (cnt_r == LAST_CNT) begin
                        state_s = DONE;
                    end else begin
                        cnt_s   = cnt_r + CNT_W'(1);
                        state_s = SEND;
                    end
                end
                DONE: begin
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                    owner_s = SRC_NONE;
                    cnt_s   = '0;
                end
            endcase
        end
    end

    // Output decode from registered state and owner only.
    always_comb begin
        sel_on_s   = 1'b0;
        shift_on_s = 1'b0;
        byte_valid = 1'b0;
        busy       = (state_r != IDLE);
        case (state_r)
            SEND: begin
                sel_on_s   = 1'b1;
                byte_valid = 1'b1;
            end
            SHIFT: begin
                sel_on_s   = 1'b1;
                // The last byte stays in place; never shift past it.
                shift_on_s = (cnt_r != LAST_CNT);
            end
            RELEASE: begin
                sel_on_s = 1'b1;
            end
            default: begin
                sel_on_s = 1'b0;
            end
        endcase
        bus_mar       = sel_on_s && (owner_r == SRC_MAR);
        bus_mdr       = sel_on_s && (owner_r == SRC_MDR);
        bus_pc        = sel_on_s && (owner_r == SRC_PC);
        mar_shift_out = shift_on_s && (owner_r == SRC_MAR);
        mdr_shift_out = shift_on_s && (owner_r == SRC_MDR);
        pc_shift_out  = shift_on_s && (owner_r == SRC_PC);
        done_mar      = (state_r == DONE) && (owner_r == SRC_MAR);
        done_mdr      = (state_r == DONE) && (owner_r == SRC_MDR);
        done_pc       = (state_r == DONE) && (owner_r == SRC_PC);
    end

endmodule

// File: tb/tb_out_bus_arbiter.sv
// tb_out_bus_arbiter
// Self-checking bench for out_bus_arbiter (NUM_BYTES = 2). Expected done
// pulses (source and cycle) are queued when a request is raised and popped
// when the DUT pulses done_*. Cycle 0 is the cycle the request goes high;
// outputs are sampled 1 time unit after each rising edge.
module tb_out_bus_arbiter;

`ifdef OUT_BUS_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
    localparam int HOLD       = 6;
`else
    localparam int TB_TIMEOUT = 255;
    localparam int HOLD       = 10;
`endif

    localparam int S_MAR = 1;
    localparam int S_MDR = 2;
    localparam int S_PC  = 3;

    logic clk = 1'b0;
    logic rst, req_mar, req_mdr, req_pc, ard_receive_ready;
    logic bus_mar, bus_mdr, bus_pc;
    logic mar_shift_out, mdr_shift_out, pc_shift_out;
    logic byte_valid, done_mar, done_mdr, done_pc, busy, error;

    typedef struct {
        int src;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks   = 0;
    int   n_fail     = 0;
    int   cyc        = 0;
    bit   auto_ready = 1'b0;

    out_bus_arbiter #(
        .NUM_BYTES     (2),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req_mar          (req_mar),
        .req_mdr          (req_mdr),
        .req_pc           (req_pc),
        .ard_receive_ready(ard_receive_ready),
        .bus_mar          (bus_mar),
        .bus_mdr          (bus_mdr),
        .bus_pc           (bus_pc),
        .mar_shift_out    (mar_shift_out),
        .mdr_shift_out    (mdr_shift_out),
        .pc_shift_out     (pc_shift_out),
        .byte_valid       (byte_valid),
        .done_mar         (done_mar),
        .done_mdr         (done_mdr),
        .done_pc          (done_pc),
        .busy             (busy),
        .error            (error)
    );

    always #5 clk = ~clk;

    // One clock: sample, check select overlap, pop the scoreboard on done,
    // drop the finished requester's req, and drive auto ready.
    task automatic tick();
        int   got;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        n_checks++;
        if ($countones({bus_mar, bus_mdr, bus_pc}) > 1) begin
            n_fail++;
            $display("FAIL select_overlap cyc %0d: got %b%b%b, required at most one high",
                     cyc, bus_mar, bus_mdr, bus_pc);
        end
        if (done_mar || done_mdr || done_pc) begin
            got = done_mar ? S_MAR : (done_mdr ? S_MDR : S_PC);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done cyc %0d: got src %0d, required none", cyc, got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e.src || cyc !== e.cyc) begin
                    n_fail++;
                    $display("FAIL done_order: got src %0d at cyc %0d, required src %0d at cyc %0d",
                             got, cyc, e.src, e.cyc);
                end
            end
            if (done_mar) req_mar = 1'b0;
            if (done_mdr) req_mdr = 1'b0;
            if (done_pc)  req_pc  = 1'b0;
        end
        if (auto_ready) ard_receive_ready = byte_valid;
    endtask

    task automatic check_sb_empty(input string name);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending_done: got %0d still queued, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        logic [11:0] outs;
        rst = 1'b1; req_mar = 1'b0; req_mdr = 1'b0; req_pc = 1'b0;
        ard_receive_ready = 1'b0; auto_ready = 1'b0;
        repeat (3) tick();
        outs = {bus_mar, bus_mdr, bus_pc, mar_shift_out, mdr_shift_out, pc_shift_out,
                byte_valid, done_mar, done_mdr, done_pc, busy, error};
        n_checks++;
        if (outs !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, required 000", outs);
        end
        rst = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (busy !== 1'b0 || bus_mar !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_req: got busy %b bus_mar %b, required 0 0", busy, bus_mar);
        end
    endtask

    task automatic test_single_pc();
        int shifts = 0;
        int shift_cyc = -1;
        auto_ready = 1'b1;
        req_pc = 1'b1;
        cyc = 0;
        exp_q.push_back('{S_PC, 7});
        repeat (9) begin
            tick();
            n_checks++;
            if (bus_pc !== (cyc >= 1 && cyc <= 6)) begin
                n_fail++;
                $display("FAIL pc_select cyc %0d: got %b, required %b", cyc, bus_pc, (cyc >= 1 && cyc <= 6));
            end
            if (pc_shift_out) begin
                shifts++;
                shift_cyc = cyc;
            end
            if (cyc == 8) begin
                n_checks++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL pc_busy_after_done: got %b, required 0", busy);
                end
            end
        end
        n_checks++;
        if (shifts != 1 || shift_cyc != 2) begin
            n_fail++;
            $display("FAIL pc_shift: got %0d strobes last at cyc %0d, required 1 at cyc 2", shifts, shift_cyc);
        end
        check_sb_empty("single_pc");
    endtask

    task automatic test_priority();
        int first_mar = -1;
        int first_mdr = -1;
        int first_pc  = -1;
        auto_ready = 1'b1;
        req_pc = 1'b1; req_mdr = 1'b1; req_mar = 1'b1;
        cyc = 0;
        exp_q.push_back('{S_MAR, 7});
        exp_q.push_back('{S_MDR, 15});
        exp_q.push_back('{S_PC, 23});
        repeat (25) begin
            tick();
            if (bus_mar && first_mar < 0) first_mar = cyc;
            if (bus_mdr && first_mdr < 0) first_mdr = cyc;
            if (bus_pc  && first_pc  < 0) first_pc  = cyc;
        end
        n_checks++;
        if (first_mar != 1 || first_mdr != 9 || first_pc != 17) begin
            n_fail++;
            $display("FAIL priority_grants: got mar %0d mdr %0d pc %0d, required 1 9 17",
                     first_mar, first_mdr, first_pc);
        end
        check_sb_empty("priority");
    endtask

    task automatic test_held_ready();
        auto_ready = 1'b0;
        ard_receive_ready = 1'b0;
        req_mdr = 1'b1;
        cyc = 0;
        exp_q.push_back('{S_MDR, HOLD + 5});
        repeat (HOLD + 7) begin
            tick();
            n_checks++;
            if (byte_valid !== (cyc == 1 || cyc == HOLD + 2)) begin
                n_fail++;
                $display("FAIL held_byte_valid cyc %0d: got %b, required %b", cyc, byte_valid,
                         (cyc == 1 || cyc == HOLD + 2));
            end
            n_checks++;
            if (mdr_shift_out !== (cyc == 2)) begin
                n_fail++;
                $display("FAIL held_shift cyc %0d: got %b, required %b", cyc, mdr_shift_out, (cyc == 2));
            end
            n_checks++;
            if (bus_mdr !== (cyc >= 1 && cyc <= HOLD + 4)) begin
                n_fail++;
                $display("FAIL held_select cyc %0d: got %b, required %b", cyc, bus_mdr,
                         (cyc >= 1 && cyc <= HOLD + 4));
            end
            ard_receive_ready = (cyc >= 1 && cyc <= HOLD) || (cyc == HOLD + 2);
        end
        check_sb_empty("held_ready");
    endtask

    task automatic test_lock();
        int first_mar = -1;
        auto_ready = 1'b1;
        req_pc = 1'b1;
        cyc = 0;
        exp_q.push_back('{S_PC, 7});
        exp_q.push_back('{S_MAR, 15});
        repeat (17) begin
            tick();
            if (cyc == 3) begin
                n_checks++;
                if (bus_pc !== 1'b1 || byte_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lock_release_state: got bus_pc %b byte_valid %b, required 1 0",
                             bus_pc, byte_valid);
                end
                req_mar = 1'b1;
            end
            if (bus_mar && first_mar < 0) first_mar = cyc;
        end
        n_checks++;
        if (first_mar != 9) begin
            n_fail++;
            $display("FAIL lock_mar_grant: got cyc %0d, required 9", first_mar);
        end
        check_sb_empty("lock");
    endtask

    task automatic test_reset_mid();
        logic [11:0] outs;
        int dn = 0;
        auto_ready = 1'b1;
        req_mdr = 1'b1;
        cyc = 0;
        repeat (4) tick();
        n_checks++;
        if (bus_mdr !== 1'b1 || byte_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_second_send: got bus_mdr %b byte_valid %b, required 1 1", bus_mdr, byte_valid);
        end
        rst = 1'b1;
        req_mdr = 1'b0;
        tick();
        outs = {bus_mar, bus_mdr, bus_pc, mar_shift_out, mdr_shift_out, pc_shift_out,
                byte_valid, done_mar, done_mdr, done_pc, busy, error};
        n_checks++;
        if (outs !== 12'h000) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got %h, required 000", outs);
        end
        rst = 1'b0;
        repeat (10) begin
            tick();
            if (done_mdr) dn++;
        end
        n_checks++;
        if (dn != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_no_done: got %0d done_mdr busy %b, required 0 0", dn, busy);
        end
        auto_ready = 1'b0;
        ard_receive_ready = 1'b0;
    endtask

`ifdef OUT_BUS_TIMEOUT_EN
    task automatic test_timeout();
        auto_ready = 1'b0;
        ard_receive_ready = 1'b0;
        req_pc = 1'b1;
        cyc = 0;
        repeat (12) begin
            tick();
            n_checks++;
            if (cyc <= 8) begin
                if (error !== 1'b0 || byte_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL timeout_wait cyc %0d: got error %b byte_valid %b, required 0 1",
                             cyc, error, byte_valid);
                end
            end else begin
                if (error !== 1'b1 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL timeout_abort cyc %0d: got error %b busy %b, required 1 0",
                             cyc, error, busy);
                end
            end
            if (cyc == 9) req_pc = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        n_checks++;
        if (error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: got %b, required 0", error);
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        req_mar = 1'b0; req_mdr = 1'b0; req_pc = 1'b0;
        ard_receive_ready = 1'b0;
        test_reset();
        test_single_pc();
        test_priority();
        test_held_ready();
        test_lock();
        test_reset_mid();
`ifdef OUT_BUS_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
